xcc_credit_tx: RTL

- Credit-based transmitter for the sending end of a link whose far end is an XCC-managed receive buffer of CREDITS entries.
- Accepts words from a local valid/ready source and forwards each one through a single register stage.
- Spends one credit per forwarded word and regains one credit per return pulse from the receiver's read side.
- Supports an orderly drain: stop sending, wait for every credit to come back, then signal completion.

---
 rtl/xcc_pkg.sv | 15 +
 rtl/xcc_credit_cnt.sv | 41 ++++
 rtl/xcc_credit_tx.sv | 76 +++++++
 3 files changed

// File: rtl/xcc_pkg.sv
// Shared types and helpers for the XCC credit transmitter slice.
package xcc_pkg;

  typedef enum logic [1:0] {
    XCT_IDLE,
    XCT_RUN,
    XCT_DRAIN
  } xct_state_e;

  // The counter must hold every value 0..credits inclusive, so it needs one bit more than $clog2.
  function automatic int crd_width(input int credits);
    return $clog2(credits) + 1;
  endfunction

endpackage

// File: rtl/xcc_credit_cnt.sv
// Saturating credit counter: starts full, counts down on send, up on return.
// A return while already full is dropped and latches a sticky error flag.
module xcc_credit_cnt
  import xcc_pkg::*;
#(
  parameter int CREDITS = 4,
  localparam int CW = crd_width(CREDITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          zero,
  output logic          full,
  output logic          err
);

  localparam logic [CW-1:0] MAX = CW'(CREDITS);

  assign zero = (cnt == '0);
  assign full = (cnt == MAX);

  // Credit count update; simultaneous dec and inc cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= MAX;
      err <= 1'b0;
    end else begin
      case ({dec, inc})
        2'b10: if (!zero) cnt <= cnt - 1'b1;
        2'b01: begin
          if (full) err <= 1'b1;
          else      cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xcc_credit_tx.sv
// Credit-based transmitter feeding a remote XCC receive buffer of CREDITS entries.
// One register stage between the local source and the link; orderly drain support.
module xcc_credit_tx
  import xcc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int DW      = 32,
  localparam int CW     = crd_width(CREDITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  input  logic          crd_rtn,
  output logic [CW-1:0] crd_cnt,
  input  logic          drain_req,
  output logic          drain_done,
  output logic          crd_err
);

  xct_state_e state, state_nxt;
  logic       xfer;
  logic       cnt_zero;
  logic       cnt_full;

  xcc_credit_cnt #(
    .CREDITS(CREDITS)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .dec  (xfer),
    .inc  (crd_rtn),
    .cnt  (crd_cnt),
    .zero (cnt_zero),
    .full (cnt_full),
    .err  (crd_err)
  );

  // A drain request in the same cycle wins over the transfer.
  assign in_rdy     = (state == XCT_RUN) & ~drain_req & ~cnt_zero;
  assign xfer       = in_vld & in_rdy;
  assign drain_done = (state == XCT_DRAIN) & cnt_full & ~out_vld;

  // Next-state selection for IDLE/RUN/DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      XCT_IDLE:  if (en)         state_nxt = XCT_RUN;
      XCT_RUN:   if (drain_req)  state_nxt = XCT_DRAIN;
      XCT_DRAIN: if (drain_done) state_nxt = XCT_IDLE;
      default:                   state_nxt = XCT_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= XCT_IDLE;
    else     state <= state_nxt;
  end

  // Output register stage; data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld <= xfer;
      if (xfer) out_data <= in_data;
    end
  end

endmodule
